// File: rtl/muldiv_pkg.sv
// Shared encodings for the sequential multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULU = 2'b00,
        OP_MULS = 2'b01,
        OP_DIVU = 2'b10,
        OP_DIVS = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_e;

endpackage

// File: rtl/seq_muldiv_addsub_n.sv
// N-bit ripple-carry adder/subtractor built from full-adder cells.
module addsub_n #(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N-1:0] b_eff;

    assign b_eff = b ^ {N{sub}};

    always_comb begin
        logic carry;
        carry = sub;
        sum   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            sum[i] = a[i] ^ b_eff[i] ^ carry;
            carry  = (a[i] & b_eff[i]) | (carry & (a[i] ^ b_eff[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/seq_muldiv.sv
// Multi-cycle shift-add multiplier / restoring divider, signed or unsigned.
module seq_muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 div_by_zero
);

    localparam int W2 = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state, state_next;
    op_e              op_r;
    logic             sign_a, sign_b, b_zero;
    logic [WIDTH-1:0] a_orig, mplier;
    logic [W2-1:0]    acc, mcand;
    logic [CW-1:0]    cnt;

    logic             is_div, acc_sign_a, acc_sign_b;
    logic [WIDTH-1:0] mag_a, mag_b, rem_next, fix_q, fix_r;
    logic [W2-1:0]    add_a, add_b, add_sum;
    logic             add_sub, add_cout;

    assign busy   = (state != IDLE);
    assign is_div = (op_r == OP_DIVU) || (op_r == OP_DIVS);

    // op[0] selects the two's-complement variants
    assign acc_sign_a = op[0] & a[WIDTH-1];
    assign acc_sign_b = op[0] & b[WIDTH-1];
    assign mag_a      = acc_sign_a ? -a : a;
    assign mag_b      = acc_sign_b ? -b : b;

    // One adder serves the multiply accumulate, the divide trial subtract
    // (remainder carried as WIDTH+1 bits, zero-extended) and the FIX negation.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_sub = 1'b0;
        if (state == FIX) begin
            add_sub = 1'b1;
            add_b   = is_div ? {{WIDTH{1'b0}}, acc[WIDTH-1:0]} : acc;
        end else if (is_div) begin
            add_sub = 1'b1;
            add_a   = {{(WIDTH-1){1'b0}}, acc[W2-1:WIDTH-1]};
            add_b   = {{WIDTH{1'b0}}, mcand[WIDTH-1:0]};
        end else begin
            add_a = acc;
            add_b = mcand;
        end
    end

    addsub_n #(.N(W2)) u_addsub (
        .a    (add_a),
        .b    (add_b),
        .sub  (add_sub),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign rem_next = add_cout ? add_sum[WIDTH-1:0] : acc[W2-2:WIDTH-1];
    assign fix_q    = (sign_a ^ sign_b) ? add_sum[WIDTH-1:0] : acc[WIDTH-1:0];
    assign fix_r    = sign_a ? -acc[W2-1:WIDTH] : acc[W2-1:WIDTH];

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (cnt == LAST) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            done        <= 1'b0;
            result      <= '0;
            div_by_zero <= 1'b0;
            op_r        <= OP_MULU;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            b_zero      <= 1'b0;
            a_orig      <= '0;
            mplier      <= '0;
            acc         <= '0;
            mcand       <= '0;
            cnt         <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: if (start) begin
                    op_r   <= op_e'(op);
                    sign_a <= acc_sign_a;
                    sign_b <= acc_sign_b;
                    b_zero <= (b == '0);
                    a_orig <= a;
                    cnt    <= '0;
                    if (op[1]) begin
                        acc   <= {{WIDTH{1'b0}}, mag_a};
                        mcand <= {{WIDTH{1'b0}}, mag_b};
                    end else begin
                        acc    <= '0;
                        mcand  <= {{WIDTH{1'b0}}, mag_a};
                        mplier <= mag_b;
                    end
                end
                RUN: begin
                    cnt <= cnt + CW'(1);
                    if (is_div) begin
                        acc <= {rem_next, acc[WIDTH-2:0], add_cout};
                    end else begin
                        if (mplier[0]) acc <= add_sum;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                    end
                end
                FIX: begin
                    done <= 1'b1;
                    if (is_div && b_zero) begin
                        result      <= {a_orig, {WIDTH{1'b1}}};
                        div_by_zero <= 1'b1;
                    end else if (is_div) begin
                        result      <= {fix_r, fix_q};
                        div_by_zero <= 1'b0;
                    end else begin
                        result      <= (sign_a ^ sign_b) ? add_sum : acc;
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/seq_muldiv.md
# seq_muldiv

Parametrised multi-cycle integer multiply/divide unit. Uses one shared add/subtract datapath and performs one shift-add or shift-subtract step per clock. Supports unsigned and two's-complement multiply and divide at any operand width, with a start/busy/done handshake. It is the general arithmetic engine for the datapath and replaces fixed 8-bit multiply-only use.

## Interface
Parameters:
- WIDTH, 8, operand width in bits; legal values are 2 or more.

Ports:
- clock  in  1  clock; all logic updates on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- op  in  2  operation: 00 unsigned mul, 01 signed mul, 10 unsigned div, 11 signed div.
- a  in  WIDTH  multiplicand or dividend.
- b  in  WIDTH  multiplier or divisor.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse marking when result and div_by_zero become valid.
- result  out  2*WIDTH  result register.
  - Multiply: the full product.
  - Divide: {remainder, quotient}, with the quotient in the low WIDTH bits.
- div_by_zero  out  1  set with done when a divide had b==0; otherwise cleared with done.

## Operation
- States: IDLE, RUN, FIX.
  - IDLE -> RUN on start=1.
  - RUN -> FIX after WIDTH iterations.
  - FIX -> IDLE unconditionally.
- Acceptance (start=1 in IDLE):
  - Latch op, a and b.
  - Record the sign flags of a and b (signed ops only).
  - Convert a and b to magnitudes.
  - Clear the iteration counter.
- RUN, multiply: each cycle, if the multiplier LSB is 1, add the shifted multiplicand to the accumulator. Then shift the multiplicand left and the multiplier right.
- RUN, divide (restoring):
  - Shift {partial remainder, dividend} left by one.
  - Trial-subtract the divisor using a WIDTH+1-bit subtractor.
  - If the difference is non-negative, keep it and set the quotient bit to 1; otherwise restore and set it to 0.
- FIX, signed sign correction:
  - Signed multiply: negate the product if sign(a) XOR sign(b).
  - Signed divide: negate the quotient if the signs differ; negate the remainder if a is negative.
  - The remainder therefore takes the sign of the dividend, and the quotient truncates toward zero.
- Division by zero:
  - Quotient = all ones; remainder = a, the original bits; div_by_zero=1.
  - The full latency still elapses.
- Signed overflow (a = most-negative, b = all ones): quotient = most-negative, remainder = 0, div_by_zero=0.
- Magnitude of the most-negative operand: treat it as the unsigned value 2^(WIDTH-1). There is no overflow inside RUN.
- Arithmetic is exact, with no truncation. result is written only in FIX.

## Timing
- Reset values: busy=0, done=0, result=0, div_by_zero=0, state IDLE.
- Reset has priority over everything else. Reset during RUN or FIX aborts the operation: no done is produced, and result is cleared.
- Latency: start is accepted at edge k.
  - busy=1 from edge k.
  - Iterations run on edges k+1..k+WIDTH.
  - FIX runs at edge k+WIDTH+1, which sets done=1, busy=0 and loads result.
  - Total: WIDTH+1 edges from accept to done.
- done is high for exactly one cycle.
- result and div_by_zero hold their values until the next FIX or reset.
- start while busy=1 is ignored; nothing is queued.
- Back-to-back: start=1 during the done cycle is accepted. Throughput is one operation per WIDTH+2 cycles.
- start held high continuously starts a new operation every WIDTH+2 cycles.
- a, b and op may change freely after acceptance.

## Structure
- Package muldiv_pkg holds:
  - op encodings: OP_MULU, OP_MULS, OP_DIVU, OP_DIVS.
  - the state enum: IDLE, RUN, FIX.
- One sub-module: addsub_n.
  - Parameter N.
  - Ports: a, b, sub, sum, cout.
  - A ripple chain of full-adder cells; sub inverts b and forces carry-in to 1.
  - Instantiate it at N=2*WIDTH for multiply accumulation and divide trial subtraction, sharing one instance. Negation in FIX may use a second instance.
- The counter width is $clog2(WIDTH+1).

## Test plan
All cases use WIDTH=8.
- op=00, a=200, b=150 -> result=0x7530; done exactly 9 edges after accept; busy low with done.
- op=01, a=0xFD (-3), b=0x05 -> 0xFFF1. op=01, a=0x80, b=0x80 -> 0x4000.
- op=10, a=200, b=7 -> 0x041C (r=4, q=28). op=11, a=0xF9 (-7), b=0x02 -> 0xFFFD (r=-1, q=-3).
- op=10, a=0x55, b=0 -> result=0x55FF, div_by_zero=1. op=11, a=0x80, b=0xFF -> 0x0080, div_by_zero=0.
- Handshake:
  - Pulse start during RUN with different operands -> ignored; the first result is unchanged.
  - start=1 in the done cycle -> the second result appears 9 edges later.
- Reset asserted on the 4th RUN cycle -> busy=0, result=0 next cycle; no done pulse.
- A new start after the reset completes normally.
